// File: rtl/seq_det_pkg.sv
// Shared definitions for the 101/110 pattern source and detectors.
// Pattern constants, select encodings and the transmitter state enum.
package seq_det_pkg;

   localparam logic [2:0] PAT_101 = 3'b101;
   localparam logic [2:0] PAT_110 = 3'b110;

   localparam logic [1:0] SEL_101     = 2'b00;
   localparam logic [1:0] SEL_110     = 2'b01;
   localparam logic [1:0] SEL_ALT_101 = 2'b10;
   localparam logic [1:0] SEL_ALT_110 = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP,
      FIN
   } state_t;

   // odd selects the second pattern of an alternating pair
   function automatic logic [2:0] pat_sel(
      input logic [1:0] s,
      input logic       odd
   );
      logic [2:0] p;
      unique case (s)
         SEL_101:     p = PAT_101;
         SEL_110:     p = PAT_110;
         SEL_ALT_101: p = odd ? PAT_110 : PAT_101;
         SEL_ALT_110: p = odd ? PAT_101 : PAT_110;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/seq_gen_101_110_tx.sv
// Serial 101/110 pattern transmitter, MSB first, with zero gap bits.
// All outputs are registered from the next-state logic.
module seq_gen_101_110_tx
   import seq_det_pkg::*;
#(
   parameter int GAP_BITS = 1,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [1:0]       sel,
   input  logic [CNT_W-1:0] count,
   output logic             out_bit,
   output logic             out_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   localparam int GW = (GAP_BITS < 2) ? 1 : $clog2(GAP_BITS + 1);
   localparam logic [GW-1:0] GAP_LAST =
      GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   state_t           state, state_n;
   logic [1:0]       bidx, bidx_n;
   logic [CNT_W-1:0] pcnt, pcnt_n;
   logic             odd, odd_n;
   logic [1:0]       sel_q, sel_n;
   logic [GW-1:0]    gcnt, gcnt_n;
   logic [2:0]       p_cur, p_new;
   logic             load;
   logic             bit_n, val_n, fs_n, busy_n, done_n;

   assign p_cur = pat_sel(sel_q, odd);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         bidx        <= '0;
         pcnt        <= '0;
         odd         <= 1'b0;
         sel_q       <= '0;
         gcnt        <= '0;
         out_bit     <= 1'b0;
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         bidx        <= bidx_n;
         pcnt        <= pcnt_n;
         odd         <= odd_n;
         sel_q       <= sel_n;
         gcnt        <= gcnt_n;
         out_bit     <= bit_n;
         out_valid   <= val_n;
         frame_start <= fs_n;
         busy        <= busy_n;
         done        <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      bidx_n  = bidx;
      pcnt_n  = pcnt;
      odd_n   = odd;
      sel_n   = sel_q;
      gcnt_n  = gcnt;
      load    = 1'b0;
      p_new   = '0;
      bit_n   = 1'b0;
      val_n   = 1'b0;
      fs_n    = 1'b0;
      done_n  = 1'b0;
      unique case (state)
         IDLE, FIN: begin
            state_n = IDLE;
            if (start) begin
               sel_n  = sel;
               odd_n  = 1'b0;
               pcnt_n = count;
               if (count == '0) begin
                  state_n = FIN;
                  done_n  = 1'b1;
               end else begin
                  state_n = SHIFT;
                  load    = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (bidx != 2'd0) begin
               bidx_n = bidx - 2'd1;
               bit_n  = p_cur[bidx_n];
               val_n  = 1'b1;
            end else if (pcnt == CNT_W'(1)) begin
               state_n = FIN;
               pcnt_n  = '0;
               done_n  = 1'b1;
            end else begin
               pcnt_n = pcnt - CNT_W'(1);
               odd_n  = ~odd;
               if (GAP_BITS == 0) begin
                  load = 1'b1;
               end else begin
                  state_n = GAP;
                  gcnt_n  = GAP_LAST;
                  val_n   = 1'b1;
               end
            end
         end
         GAP: begin
            if (gcnt == '0) begin
               state_n = SHIFT;
               load    = 1'b1;
            end else begin
               gcnt_n = gcnt - GW'(1);
               val_n  = 1'b1;
            end
         end
      endcase
      // a new pattern starts with its MSB and a frame marker
      if (load) begin
         p_new  = pat_sel(sel_n, odd_n);
         bidx_n = 2'd2;
         bit_n  = p_new[2];
         val_n  = 1'b1;
         fs_n   = 1'b1;
      end
      busy_n = (state_n == SHIFT) || (state_n == GAP);
   end

endmodule

// File: tb/tb_seq_gen_101_110_tx.sv
// Bench for seq_gen_101_110_tx at GAP_BITS 0, 1 and 2.
// Streams are checked cycle by cycle against a list-built reference.
module tb_seq_gen_101_110_tx;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [2:0]    st = '0;
   logic [1:0]    sel = '0;
   logic [CW-1:0] count = '0;
   logic [2:0]    ob, ov, fs, bz, dn;

   int n_chk = 0;
   int n_fail = 0;

   logic [4:0] exp_q[$];

   always #5 clk = ~clk;

   seq_gen_101_110_tx #(.GAP_BITS(0), .CNT_W(CW)) u_g0 (
      .clk(clk), .rstn(rstn), .start(st[0]), .sel(sel),
      .count(count), .out_bit(ob[0]), .out_valid(ov[0]),
      .frame_start(fs[0]), .busy(bz[0]), .done(dn[0])
   );
   seq_gen_101_110_tx #(.GAP_BITS(1), .CNT_W(CW)) u_g1 (
      .clk(clk), .rstn(rstn), .start(st[1]), .sel(sel),
      .count(count), .out_bit(ob[1]), .out_valid(ov[1]),
      .frame_start(fs[1]), .busy(bz[1]), .done(dn[1])
   );
   seq_gen_101_110_tx #(.GAP_BITS(2), .CNT_W(CW)) u_g2 (
      .clk(clk), .rstn(rstn), .start(st[2]), .sel(sel),
      .count(count), .out_bit(ob[2]), .out_valid(ov[2]),
      .frame_start(fs[2]), .busy(bz[2]), .done(dn[2])
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] ref_pat(input logic [1:0] s, input int k);
      logic [2:0] first, other;
      first = s[0] ? 3'b110 : 3'b101;
      other = s[0] ? 3'b101 : 3'b110;
      if (s[1] && (k % 2 == 1)) return other;
      return first;
   endfunction

   // record = {out_bit, out_valid, frame_start, busy, done}
   task automatic build(input logic [1:0] s, input int n, input int gap);
      logic [2:0] p;
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         p = ref_pat(s, k);
         for (int b = 2; b >= 0; b--)
            exp_q.push_back({p[b], 1'b1, (b == 2), 1'b1, 1'b0});
         if (k < n - 1)
            for (int j = 0; j < gap; j++)
               exp_q.push_back(5'b01010);
      end
      exp_q.push_back(5'b00001);
   endtask

   function automatic int detect(input logic b[$]);
      int c = 0;
      int s = 0;
      logic [2:0] w;
      for (int j = 0; j < b.size(); j++) begin
         if (j - s >= 2) begin
            w = {b[j-2], b[j-1], b[j]};
            if (w == 3'b101 || w == 3'b110) begin
               c++;
               s = j + 1;
            end
         end
      end
      return c;
   endfunction

   function automatic logic [4:0] obs(input int g);
      return {ob[g], ov[g], fs[g], bz[g], dn[g]};
   endfunction

   task automatic go(input int g, input logic [1:0] s, input int n);
      st[g] = 1'b1;
      sel = s;
      count = CW'(n);
   endtask

   // start must already be driven; returns in the FIN cycle when chaining
   task automatic run(input int g, input logic [1:0] s, input int n,
                      input int glitch, input bit chain,
                      input logic [1:0] ns, input int nn,
                      input string nm);
      logic bq[$];
      logic [4:0] o;
      int fc, fd, ed, det;
      build(s, n, g);
      fc = 0;
      fd = -1;
      step();
      st[g] = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         o = obs(g);
         n_chk++;
         if (o !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s cyc %0d got %b want %b", nm, i, o, exp_q[i]);
         end
         bq.push_back(ob[g]);
         if (fs[g] === 1'b1) fc++;
         if (dn[g] === 1'b1 && fd < 0) fd = i;
         if (i == glitch) begin
            st[g] = 1'b1;
            sel = 2'b01;
            count = CW'(9);
         end else begin
            st[g] = 1'b0;
         end
         if (chain && i == exp_q.size() - 1) go(g, ns, nn);
         if (i < exp_q.size() - 1) step();
      end
      if (!chain) begin
         step();
         n_chk++;
         if (obs(g) !== 5'b0) begin
            n_fail++;
            $display("FAIL %s idle got %b want 00000", nm, obs(g));
         end
      end
      ed = (n == 0) ? 0 : 3 * n + g * (n - 1);
      n_chk++;
      if (fd != ed) begin
         n_fail++;
         $display("FAIL %s done_idx got %0d want %0d", nm, fd, ed);
      end
      n_chk++;
      if (fc != n) begin
         n_fail++;
         $display("FAIL %s frames got %0d want %0d", nm, fc, n);
      end
      det = detect(bq);
      n_chk++;
      if (det != n) begin
         n_fail++;
         $display("FAIL %s detections got %0d want %0d", nm, det, n);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      st = '0;
      repeat (3) step();
      for (int g = 0; g < 3; g++) begin
         n_chk++;
         if (obs(g) !== 5'b0) begin
            n_fail++;
            $display("FAIL reset g%0d got %b want 00000", g, obs(g));
         end
      end
      rstn = 1'b1;
      step();
      n_chk++;
      if (obs(1) !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_rel got %b want 00000", obs(1));
      end
   endtask

   task automatic test_basic();
      go(1, 2'b00, 3);
      run(1, 2'b00, 3, -1, 1'b0, 2'b00, 0, "basic101");
   endtask

   task automatic test_alt_b2b();
      go(0, 2'b10, 4);
      run(0, 2'b10, 4, -1, 1'b0, 2'b00, 0, "alt101_gap0");
   endtask

   task automatic test_zero();
      go(1, 2'b01, 0);
      run(1, 2'b01, 0, -1, 1'b0, 2'b00, 0, "count0");
   endtask

   task automatic test_ignore_fin();
      go(1, 2'b00, 3);
      run(1, 2'b00, 3, 2, 1'b1, 2'b01, 2, "ignore");
      run(1, 2'b01, 2, -1, 1'b0, 2'b00, 0, "fin_b2b");
   endtask

   task automatic test_reset_mid();
      go(1, 2'b00, 3);
      step();
      st[1] = 1'b0;
      repeat (5) step();
      rstn = 1'b0;
      step();
      for (int g = 0; g < 3; g++) begin
         n_chk++;
         if (obs(g) !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid g%0d got %b want 00000", g, obs(g));
         end
      end
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_chk++;
         if (obs(1) !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_nodone cyc %0d got %b want 00000", i, obs(1));
         end
      end
      go(1, 2'b01, 2);
      run(1, 2'b01, 2, -1, 1'b0, 2'b00, 0, "after_rst");
   endtask

   task automatic test_long();
      go(2, 2'b11, 255);
      run(2, 2'b11, 255, -1, 1'b0, 2'b00, 0, "long255");
   endtask

   task automatic test_random();
      int g, k, n, nn, gl, sz;
      logic [1:0] s, ns;
      for (int it = 0; it < 8; it++) begin
         g = $urandom_range(0, 2);
         k = $urandom_range(1, 3);
         s = 2'($urandom_range(0, 3));
         n = $urandom_range(0, 12);
         go(g, s, n);
         for (int j = 0; j < k; j++) begin
            ns = 2'($urandom_range(0, 3));
            nn = $urandom_range(0, 12);
            sz = (n == 0) ? 1 : 3 * n + g * (n - 1) + 1;
            gl = (sz > 1 && $urandom_range(0, 1) == 1)
                 ? $urandom_range(0, sz - 2) : -1;
            run(g, s, n, gl, (j < k - 1), ns, nn, "random");
            s = ns;
            n = nn;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_alt_b2b();
      test_zero();
      test_ignore_fin();
      test_reset_mid();
      test_long();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_gen_101_110_tx.md
Name: seq_gen_101_110_tx

Overview:
Serial pattern transmitter that is the source side of the team's non-overlapping 101/110 Mealy detectors. On a start request it emits a programmed number of 3-bit patterns (101, 110, or alternating) MSB first, one bit per clock. Patterns are separated by a configurable run of zero gap bits. Used as stimulus and link-test source feeding a detector's `in` pin; a downstream detector counts exactly `count` detections.

Parameters:
GAP_BITS, 1, number of '0' bits inserted between consecutive patterns (0 allowed; no gap after the last pattern)
CNT_W, 8, width of the pattern repeat count

Ports:
clk  input  1  clock, all logic on posedge
rstn  input  1  synchronous active-low reset
start  input  1  request pulse; sampled only when busy=0 and done=0 or busy=0 and done=1 (i.e. whenever busy=0)
sel  input  2  pattern select, captured with start: 00=101, 01=110, 10=alternate starting 101, 11=alternate starting 110
count  input  CNT_W  number of patterns to send, captured with start
out_bit  output  1  serial data, registered
out_valid  output  1  high on every pattern and gap bit
frame_start  output  1  high with the first (MSB) bit of each pattern
busy  output  1  high while the transmission is in progress
done  output  1  single-cycle pulse after the last bit

Behaviour:
- Reset (rstn=0 at posedge): state IDLE. out_bit=0, out_valid=0, frame_start=0, busy=0, done=0, and all counters cleared. Reset mid-transmission aborts immediately with no done pulse.
- Interface: clock clk; reset rstn, synchronous, active-low.
- States:
  - IDLE: wait for start.
  - SHIFT: 3 cycles per pattern, bit index 2→0.
  - GAP: GAP_BITS cycles.
  - FIN: 1 cycle.
- Start accepted at posedge T when busy=0 (IDLE or FIN). sel and count are latched. Later changes on sel/count are ignored until the next accept. start while busy=1 is ignored and has no effect.
- count=0: no bits are sent and out_valid stays 0. Go to FIN, so done=1 at cycle T+1 and busy stays 0.
- count=N>0:
  - Pattern k occupies cycles T+1+k·(3+GAP_BITS) … +2. frame_start=1 on its first cycle.
  - GAP bits follow each pattern except the last: out_bit=0, out_valid=1, frame_start=0.
  - Last bit lands at cycle L = T + 3N + GAP_BITS·(N−1).
  - busy=1 over cycles T+1..L. done=1 at L+1 with busy=0 and out_valid=0.
- Alternating modes: pattern index k even uses the starting pattern and k odd uses the other one.
- Outside transmission, out_bit=0 and out_valid=0.
- Pattern counter is CNT_W bits and counts down from N to 1; there is no wrap. N=2^CNT_W−1 must complete correctly.
- Gap counter width is clog2(GAP_BITS+1), minimum 1. With GAP_BITS=0 the GAP state is skipped and patterns are back-to-back.
- start accepted in the FIN cycle begins a new transmission at the next cycle (back-to-back), with first bit at FIN+1.
- Detector guarantee: feeding out_bit into a non-overlapping 101/110 detector yields exactly N detections for every sel and every GAP_BITS ≥ 0.

Decomposition:
- Shared package seq_det_pkg holds:
  - pattern constants PAT_101=3'b101, PAT_110=3'b110
  - sel encodings SEL_101, SEL_110, SEL_ALT_101, SEL_ALT_110
  - state enum {IDLE, SHIFT, GAP, FIN}
- Single module; no sub-module is warranted. Pattern selection is a 2-input mux driven by the latched sel and pattern-index LSB.

Test Plan:
1. Reset, then start with sel=00, count=3, GAP_BITS=1 → out_bit stream 101 0 101 0 101 from T+1. frame_start at T+1, T+5, T+9. done at T+12. busy=1 over T+1..T+11.
2. sel=10, count=4, GAP_BITS=0 → 101110101110 back-to-back. done at T+13. The companion detector reports 4 outputs.
3. count=0 → done at T+1, busy never high, out_valid stays 0.
4. start re-pulsed mid-stream with sel=01, count=9 → ignored; the original stream completes unchanged. Then start in the FIN cycle → next stream's first bit at FIN+1.
5. rstn=0 asserted during the 2nd pattern → next cycle all outputs are 0 and there is no done pulse. A start after reset release transmits normally.
6. sel=11, count=255 (CNT_W=8), GAP_BITS=2 → 255 frame_start pulses alternating 110/101. done occurs exactly at T + 3·255 + 2·254 + 1.
